mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage controller that sits directly downstream of instruction decode.
- Consumes the decoded control bits (load, store, mem-op, byte-op) plus the effective address and store data.
- Runs a request/response handshake with data memory and stalls the pipeline until the access completes.
- Presents zero-extended load data for register-file writeback.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width; fixed at 4 byte lanes

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  instruction in mem stage is valid
- is_mem_op_i  in  1  decoded: load or store
- is_load_op_i  in  1  decoded: load (LW/LBU)
- is_store_op_i  in  1  decoded: store (SW/SB)
- is_byte_op_i  in  1  decoded: byte access (LBU/SB)
- addr_i  in  ADDR_W  effective byte address
- store_data_i  in  DATA_W  rt value for stores
- dmem_req_valid_o  out  1  request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_addr_o  out  ADDR_W  word-aligned address; bits [1:0] are always 0
- dmem_wen_o  out  1  1 = write, 0 = read
- dmem_mask_o  out  4  byte-lane write enables
- dmem_wdata_o  out  DATA_W  write data, lane-replicated
- dmem_resp_valid_i  in  1  read data valid
- dmem_rdata_i  in  DATA_W  read word
- stall_o  out  1  hold the upstream pipeline
- load_valid_o  out  1  one-cycle pulse: load_data_o valid
- load_data_o  out  DATA_W  writeback data
- misalign_o  out  1  misaligned-word flag; see Optional Feature

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; captured registers 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If valid_i & is_mem_op_i: capture addr, data and ctrl bits, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Drive dmem_req_valid_o=1 with registered addr/wen/mask/wdata; hold them stable until ready.
  - On dmem_req_ready_i: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - On dmem_resp_valid_i: register the extracted load data, then go to DONE.
  - dmem_resp_valid_i is ignored in every state except WAIT.
- DONE:
  - load_valid_o=1 for loads only, for exactly one cycle.
  - Return to IDLE.
- stall_o:
  - = (state==IDLE & valid_i & is_mem_op_i) | state==REQ | state==WAIT.
  - Low in DONE, which lets the pipeline advance.
  - Upstream holds all inputs stable while stall_o=1.
- Latency with zero wait states: store takes 3 cycles (IDLE, REQ, DONE); load takes 4.
- Back-to-back memory ops re-enter via IDLE; there is no overlap.
- Non-mem or invalid instructions: no stall and no request.
- Byte store: mask = 1<<addr[1:0]; wdata = store_data[7:0] replicated to all 4 lanes.
- Word store: mask = 4'hF.
- Any read: mask = 4'h0.
- Byte load: lane addr[1:0] of rdata, zero-extended to 32 bits.
- Word load: rdata passes through unchanged.
- load_data_o holds its last value between pulses.
- Reset mid-operation: immediate return to IDLE; an in-flight response is dropped.
- is_load_op_i and is_store_op_i both high is illegal; store takes priority.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- With the macro defined:
  - A word access with addr[1:0]!=0 goes IDLE→DONE with no dmem request.
  - misalign_o=1 for the DONE cycle; load_valid_o stays 0.
- Without the macro:
  - addr[1:0] are ignored for word accesses.
  - misalign_o is tied to 0; the port is always present.

Decomposition:
- Shared definitions package:
  - mem_state_e enum (IDLE/REQ/WAIT/DONE)
  - mem_req_s struct (addr, wen, mask, wdata)
  - constants kLaneBits=2 and kWordMask=4'hF
- Sub-module mem_byte_lane, combinational:
  - store mask and data replication from (is_byte, addr[1:0], data)
  - load lane extract and zero-extend from (is_byte, addr[1:0], rdata)

Test Plan:
- SW addr 0x104 data 0xDEADBEEF, ready=1 → one req: addr 0x104, wen=1, mask F, wdata DEADBEEF; stall for 2 cycles, then released.
- SB addr 0x203 data 0x...5A → mask 4'b1000, wdata 0x5A5A5A5A.
- LBU addr 0x302, rdata 0x11223344 returned 2 cycles after accept → load_valid_o pulse with 0x00000022; stall held through WAIT.
- LW with ready low for 3 cycles → req fields stable throughout; exactly one handshake; load_data_o = rdata.
- Reset asserted while in WAIT, followed by a late resp_valid → IDLE, outputs 0, no load_valid_o.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x101 → no dmem_req_valid_o, misalign_o pulses once; without the macro, the request goes to 0x100.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_access_unit_pkg;

  localparam int kAddrW    = 32;
  localparam int kDataW    = 32;
  localparam int kLaneBits = 2;
  localparam logic [3:0] kWordMask = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [kAddrW-1:0] addr;
    logic              wen;
    logic [3:0]        mask;
    logic [kDataW-1:0] wdata;
  } mem_req_s;

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Byte-lane steering: store mask/replication and load lane extraction with zero-extension.
module mem_byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic                 st_is_byte_i,
  input  logic [kLaneBits-1:0] st_lane_i,
  input  logic [kDataW-1:0]    st_data_i,
  output logic [3:0]           st_mask_o,
  output logic [kDataW-1:0]    st_wdata_o,
  input  logic                 ld_is_byte_i,
  input  logic [kLaneBits-1:0] ld_lane_i,
  input  logic [kDataW-1:0]    ld_rdata_i,
  output logic [kDataW-1:0]    ld_data_o
);

  // Store side: one-hot lane mask and byte replicated across all lanes.
  always_comb begin
    st_mask_o  = kWordMask;
    st_wdata_o = st_data_i;
    if (st_is_byte_i) begin
      st_mask_o  = 4'b0001 << st_lane_i;
      st_wdata_o = {4{st_data_i[7:0]}};
    end else begin
      st_mask_o  = kWordMask;
      st_wdata_o = st_data_i;
    end
  end

  // Load side: pick the addressed byte and zero-extend it.
  always_comb begin
    ld_data_o = ld_rdata_i;
    if (ld_is_byte_i) begin
      case (ld_lane_i)
        2'd0:    ld_data_o = {24'h000000, ld_rdata_i[7:0]};
        2'd1:    ld_data_o = {24'h000000, ld_rdata_i[15:8]};
        2'd2:    ld_data_o = {24'h000000, ld_rdata_i[23:16]};
        2'd3:    ld_data_o = {24'h000000, ld_rdata_i[31:24]};
        default: ld_data_o = {kDataW{1'b0}};
      endcase
    end else begin
      ld_data_o = ld_rdata_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one dmem request/response per mem op, stalling upstream until done.
// Optional misaligned-word trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              is_mem_op_i,
  input  logic              is_load_op_i,
  input  logic              is_store_op_i,
  input  logic              is_byte_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_wen_o,
  output logic [3:0]        dmem_mask_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_resp_valid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              misalign_o
);

  mem_state_e           state_q, state_d;
  mem_req_s             req_q, req_d;
  logic                 is_byte_q, is_byte_d;
  logic                 is_load_q, is_load_d;
  logic [kLaneBits-1:0] lane_q, lane_d;
  logic [DATA_W-1:0]    load_data_q, load_data_d;
  logic                 start_s;
  logic [3:0]           st_mask_s;
  logic [DATA_W-1:0]    st_wdata_s;
  logic [DATA_W-1:0]    ld_data_s;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                 mis_q, mis_d;
`endif

  assign start_s = valid_i & is_mem_op_i;

  mem_byte_lane u_lane (
    .st_is_byte_i (is_byte_op_i),
    .st_lane_i    (addr_i[kLaneBits-1:0]),
    .st_data_i    (store_data_i),
    .st_mask_o    (st_mask_s),
    .st_wdata_o   (st_wdata_s),
    .ld_is_byte_i (is_byte_q),
    .ld_lane_i    (lane_q),
    .ld_rdata_i   (dmem_rdata_i),
    .ld_data_o    (ld_data_s)
  );

  // Next-state and capture logic; store wins when load and store are both decoded.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    is_byte_d   = is_byte_q;
    is_load_d   = is_load_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_s) begin
          req_d.addr  = {addr_i[ADDR_W-1:kLaneBits], 2'b00};
          req_d.wen   = is_store_op_i;
          req_d.mask  = is_store_op_i ? st_mask_s : 4'h0;
          req_d.wdata = is_store_op_i ? st_wdata_s : {DATA_W{1'b0}};
          is_byte_d   = is_byte_op_i;
          is_load_d   = is_load_op_i & ~is_store_op_i;
          lane_d      = addr_i[kLaneBits-1:0];
`ifdef MEM_MISALIGN_TRAP_EN
          mis_d       = ~is_byte_op_i & (addr_i[kLaneBits-1:0] != 2'b00);
          state_d     = mis_d ? DONE : REQ;
`else
          state_d     = REQ;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem_req_ready_i) begin
          state_d = req_q.wen ? DONE : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (dmem_resp_valid_i) begin
          load_data_d = ld_data_s;
          state_d     = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      is_byte_q   <= 1'b0;
      is_load_q   <= 1'b0;
      lane_q      <= 2'b00;
      load_data_q <= {DATA_W{1'b0}};
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      is_byte_q   <= is_byte_d;
      is_load_q   <= is_load_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign dmem_req_valid_o = (state_q == REQ);
  assign dmem_addr_o      = req_q.addr;
  assign dmem_wen_o       = req_q.wen;
  assign dmem_mask_o      = req_q.mask;
  assign dmem_wdata_o     = req_q.wdata;
  assign load_data_o      = load_data_q;
  assign stall_o          = ((state_q == IDLE) & start_s) | (state_q == REQ) | (state_q == WAIT);
`ifdef MEM_MISALIGN_TRAP_EN
  assign load_valid_o     = (state_q == DONE) & is_load_q & ~mis_q;
  assign misalign_o       = (state_q == DONE) & mis_q;
`else
  assign load_valid_o     = (state_q == DONE) & is_load_q;
  assign misalign_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops, memory responder, decoupled monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, is_mem_op_i, is_load_op_i, is_store_op_i, is_byte_op_i;
  logic [31:0] addr_i, store_data_i;
  logic        dmem_req_valid_o, dmem_req_ready_i, dmem_wen_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, load_data_o;
  logic [3:0]  dmem_mask_o;
  logic        dmem_resp_valid_i, stall_o, load_valid_o, misalign_o;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .is_mem_op_i(is_mem_op_i),
    .is_load_op_i(is_load_op_i), .is_store_op_i(is_store_op_i), .is_byte_op_i(is_byte_op_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .dmem_req_valid_o(dmem_req_valid_o),
    .dmem_req_ready_i(dmem_req_ready_i), .dmem_addr_o(dmem_addr_o), .dmem_wen_o(dmem_wen_o),
    .dmem_mask_o(dmem_mask_o), .dmem_wdata_o(dmem_wdata_o), .dmem_resp_valid_i(dmem_resp_valid_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .load_valid_o(load_valid_o),
    .load_data_o(load_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_ld_q[$];
  int          exp_mis = 0;
  int          hs_count = 0;
  int          req_pushed = 0;
  int          checks = 0;
  int          errors = 0;
  int          rdy_dly = 0;
  int          rsp_dly = 1;
  logic [31:0] rd_word = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.wen = w; r.mask = m; r.wdata = wd;
    exp_req_q.push_back(r);
    req_pushed++;
  endtask

  task automatic clear_inputs();
    valid_i = 1'b0; is_mem_op_i = 1'b0; is_load_op_i = 1'b0; is_store_op_i = 1'b0;
    is_byte_op_i = 1'b0; addr_i = 32'h0; store_data_i = 32'h0;
  endtask

  task automatic drive_op(input logic st, input logic by, input logic [31:0] a, input logic [31:0] d);
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_load_op_i = ~st; is_store_op_i = st;
    is_byte_op_i = by; addr_i = a; store_data_i = d;
  endtask

  task automatic run_op(input logic st, input logic by, input logic [31:0] a, input logic [31:0] d,
                        input int rdly, input int sdly, input logic [31:0] rd, input int exp_stall);
    int stalls = 0;
    bit done = 1'b0;
    rdy_dly = rdly; rsp_dly = sdly; rd_word = rd;
    @(posedge clk); #1;
    drive_op(st, by, a, d);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1'b1;
    end
    clear_inputs();
    if (!done) check("op_timeout", 32'd0, 32'd1);
    else check("stall_cycles", 32'(stalls), 32'(exp_stall));
    repeat (2) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_valid"}, {31'd0, dmem_req_valid_o}, 32'd0);
    check({tag, "_addr"}, dmem_addr_o, 32'd0);
    check({tag, "_wen_mask"}, {27'd0, dmem_wen_o, dmem_mask_o}, 32'd0);
    check({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    check({tag, "_stall_ldv_mis"}, {29'd0, stall_o, load_valid_o, misalign_o}, 32'd0);
    check({tag, "_load_data"}, load_data_o, 32'd0);
  endtask

  // Memory responder: ready after rdy_dly REQ cycles, read data rsp_dly cycles after accept.
  initial begin
    bit pend = 1'b0;
    int cnt = 0;
    int req_wait = 0;
    dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (pend) begin
        if (cnt <= 1) begin
          dmem_resp_valid_i = 1'b1; dmem_rdata_i = rd_word; pend = 1'b0;
        end else begin
          cnt--; dmem_resp_valid_i = 1'b0;
        end
      end else begin
        dmem_resp_valid_i = 1'b0;
      end
      if (dmem_req_valid_o) begin
        if (req_wait >= rdy_dly) begin
          dmem_req_ready_i = 1'b1;
          if (!dmem_wen_o) begin pend = 1'b1; cnt = rsp_dly; end
        end else begin
          dmem_req_ready_i = 1'b0;
        end
        req_wait++;
      end else begin
        dmem_req_ready_i = 1'b0; req_wait = 0;
      end
    end
  end

  // Monitor: compares requests every REQ cycle (stability) and pops on handshake.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dmem_req_valid_o) begin
          check("req_expected", (exp_req_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_req_q.size() > 0) begin
            e = exp_req_q[0];
            check("req_addr", dmem_addr_o, e.addr);
            check("req_wen", {31'd0, dmem_wen_o}, {31'd0, e.wen});
            check("req_mask", {28'd0, dmem_mask_o}, {28'd0, e.mask});
            check("req_wdata", dmem_wdata_o, e.wdata);
            if (dmem_req_ready_i) begin
              void'(exp_req_q.pop_front());
              hs_count++;
            end
          end
        end
        if (load_valid_o) begin
          check("load_expected", (exp_ld_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_ld_q.size() > 0) check("load_data", load_data_o, exp_ld_q.pop_front());
        end
        if (misalign_o) begin
          check("misalign_expected", (exp_mis > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_mis > 0) exp_mis--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hs_before;
    int stalls;
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // SW 0x104
    push_req(32'h0000_0104, 1'b1, 4'hF, 32'hDEAD_BEEF);
    run_op(1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1, 32'h0, 2);
    // SB 0x203
    push_req(32'h0000_0200, 1'b1, 4'b1000, 32'h5A5A_5A5A);
    run_op(1'b1, 1'b1, 32'h0000_0203, 32'h1234_565A, 0, 1, 32'h0, 2);
    // LBU 0x302, response two cycles after accept
    push_req(32'h0000_0300, 1'b0, 4'h0, 32'h0);
    exp_ld_q.push_back(32'h0000_0022);
    run_op(1'b0, 1'b1, 32'h0000_0302, 32'h0, 0, 2, 32'h1122_3344, 4);
    // LW 0x400 with ready held low for three cycles
    push_req(32'h0000_0400, 1'b0, 4'h0, 32'h0);
    exp_ld_q.push_back(32'hCAFE_F00D);
    run_op(1'b0, 1'b0, 32'h0000_0400, 32'h0, 3, 1, 32'hCAFE_F00D, 6);
    // SB lane 0; load data must hold its last value
    push_req(32'h0000_0500, 1'b1, 4'b0001, 32'hA5A5_A5A5);
    run_op(1'b1, 1'b1, 32'h0000_0500, 32'hFFFF_FFA5, 0, 1, 32'h0, 2);
    check("load_data_hold", load_data_o, 32'hCAFE_F00D);
    // LBU lane 3 with high bit set: zero-extended
    push_req(32'h0000_0600, 1'b0, 4'h0, 32'h0);
    exp_ld_q.push_back(32'h0000_0080);
    run_op(1'b0, 1'b1, 32'h0000_0603, 32'h0, 0, 1, 32'h80FF_0102, 3);

    // Non-mem and invalid instructions: no stall, no request
    hs_before = hs_count;
    @(posedge clk); #1;
    valid_i = 1'b1; is_mem_op_i = 1'b0; addr_i = 32'h0000_0800;
    repeat (3) begin
      @(negedge clk);
      check("nonmem_stall", {31'd0, stall_o}, 32'd0);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; is_mem_op_i = 1'b1; is_load_op_i = 1'b1;
    @(negedge clk);
    check("invalid_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("nonmem_no_handshake", 32'(hs_count), 32'(hs_before));

    // Reset while waiting for a load response; late response must be dropped
    push_req(32'h0000_0700, 1'b0, 4'h0, 32'h0);
    rdy_dly = 0; rsp_dly = 6; rd_word = 32'hBADB_AD00;
    @(posedge clk); #1;
    drive_op(1'b0, 1'b0, 32'h0000_0700, 32'h0);
    stalls = 0;
    repeat (3) begin
      @(negedge clk);
      if (stall_o) stalls++;
    end
    check("wait_stall_before_reset", 32'(stalls), 32'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_reset_load_data", load_data_o, 32'd0);
    check("post_reset_stall", {31'd0, stall_o}, 32'd0);

    // Misaligned word load at 0x101
`ifdef MEM_MISALIGN_TRAP_EN
    hs_before = hs_count;
    exp_mis++;
    run_op(1'b0, 1'b0, 32'h0000_0101, 32'h0, 0, 1, 32'h5566_7788, 1);
    check("misalign_no_handshake", 32'(hs_count), 32'(hs_before));
`else
    push_req(32'h0000_0100, 1'b0, 4'h0, 32'h0);
    exp_ld_q.push_back(32'h5566_7788);
    run_op(1'b0, 1'b0, 32'h0000_0101, 32'h0, 0, 1, 32'h5566_7788, 3);
`endif

    repeat (3) @(posedge clk);
    check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    check("load_queue_empty", 32'(exp_ld_q.size()), 32'd0);
    check("misalign_pending", 32'(exp_mis), 32'd0);
    check("handshake_count", 32'(hs_count), 32'(req_pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
